// File: rtl/screen_wr_bridge.sv
// Screen-window store filter and FIFO between the CPU write port
// and the VGA framebuffer write port.
module screen_wr_bridge #(
  parameter int          DEPTH        = 16,
  parameter logic [14:0] SCREEN_BASE  = 15'h4000,
  parameter int          SCREEN_WORDS = 8192
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       write_m,
  input  logic [14:0]                data_addr,
  input  logic [15:0]                out_m,
  input  logic                       fb_ready,
  output logic                       fb_wren,
  output logic [12:0]                fb_addr,
  output logic [15:0]                fb_data,
  input  logic                       ovf_clr,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [16:0] BASE17 = 17'(SCREEN_BASE);
  localparam logic [16:0] TOP17  = 17'(SCREEN_BASE) + 17'(SCREEN_WORDS);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [28:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          fb_wren_q, fb_wren_d;
  logic [12:0]   fb_addr_q, fb_addr_d;
  logic [15:0]   fb_data_q, fb_data_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic [16:0]   addr17;
  logic [12:0]   off;
  logic [AW-1:0] tail_ptr;
  logic [28:0]   head;
  logic [12:0]   tail_addr;
  logic          hit, pop, coalesce, push, drop;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;

  always_comb begin
    addr17    = {2'b00, data_addr};
    hit       = write_m && (addr17 >= BASE17) && (addr17 < TOP17);
    off       = data_addr[12:0] - SCREEN_BASE[12:0];
    tail_ptr  = wr_ptr_q - AW'(1);
    head      = mem_q[rd_ptr_q];
    tail_addr = mem_q[tail_ptr][28:16];
    pop       = fb_ready && (level_q != '0);
    // A tail that is leaving this cycle can no longer absorb the store
    coalesce  = hit && (level_q != '0)
              && !((level_q == LW'(1)) && pop)
              && (tail_addr == off);
    push      = hit && !coalesce && ((level_q != FULL) || pop);
    drop      = hit && !coalesce && (level_q == FULL) && !pop;
    mem_we    = push || coalesce;
    mem_waddr = coalesce ? tail_ptr : wr_ptr_q;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    fb_wren_d  = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      fb_wren_d = 1'b1;
      fb_addr_d = head[28:16];
      fb_data_d = head[15:0];
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_clr)
        drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF)
        drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      fb_wren_q  <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      fb_wren_q  <= fb_wren_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetN && mem_we) mem_q[mem_waddr] <= {off, out_m};
  end

  assign fb_wren  = fb_wren_q;
  assign fb_addr  = fb_addr_q;
  assign fb_data  = fb_data_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_screen_wr_bridge.sv
// Bench for screen_wr_bridge: vector table plus hand sequences,
// framebuffer writes checked against a scoreboard queue.
module tb_screen_wr_bridge;

  logic        clk = 1'b0;
  logic        resetN;
  logic        write_m;
  logic [14:0] data_addr;
  logic [15:0] out_m;
  logic        fb_ready;
  logic        fb_wren;
  logic [12:0] fb_addr;
  logic [15:0] fb_data;
  logic        ovf_clr;
  logic [4:0]  level;
  logic        overflow;
  logic [7:0]  drop_cnt;

  screen_wr_bridge dut (
    .clk(clk), .resetN(resetN), .write_m(write_m),
    .data_addr(data_addr), .out_m(out_m), .fb_ready(fb_ready),
    .fb_wren(fb_wren), .fb_addr(fb_addr), .fb_data(fb_data),
    .ovf_clr(ovf_clr), .level(level), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] a;
    logic [15:0] d;
  } ent_t;

  typedef struct {
    logic        wm;
    logic [14:0] addr;
    logic [15:0] data;
    logic        rdy;
    int          exp_level;
    logic        exp_wren;
    logic [12:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  ent_t mq[$];
  ent_t sb[$];
  bit   movf;
  int   mcnt;
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rn, input logic wm,
                      input logic [14:0] a, input logic [15:0] d,
                      input logic rdy, input logic clr);
    bit   h, mp, mc, full;
    ent_t e;
    resetN = rn; write_m = wm; data_addr = a; out_m = d;
    fb_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    if (!rn) begin
      mq.delete(); sb.delete(); movf = 0; mcnt = 0;
    end else begin
      h    = wm && a >= 15'h4000 && a < 15'h6000;
      mp   = rdy && mq.size() != 0;
      full = mq.size() == 16;
      mc   = h && mq.size() != 0 && !(mq.size() == 1 && mp)
             && mq[mq.size()-1].a == a[12:0];
      if (mp) sb.push_back(mq.pop_front());
      if (h && mc) begin
        mq[mq.size()-1].d = d;
      end else if (h && (!full || mp)) begin
        e.a = a[12:0]; e.d = d; mq.push_back(e);
      end else if (h) begin
        movf = 1;
        mcnt = clr ? 1 : (mcnt < 255 ? mcnt + 1 : 255);
      end
      if (!(h && !mc && full && !mp) && clr) begin
        movf = 0; mcnt = 0;
      end
    end
    #1;
    chk("level", level, mq.size());
    chk("overflow", overflow, movf);
    chk("drop_cnt", drop_cnt, mcnt);
    if (fb_wren) begin
      if (sb.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL spurious_wr: got %0h/%0h expected none",
                 fb_addr, fb_data);
      end else begin
        e = sb.pop_front();
        chk("fb_addr", fb_addr, e.a);
        chk("fb_data", fb_data, e.d);
      end
    end
    if (sb.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL missing_wr: got fb_wren=0 expected %0h/%0h",
               sb[0].a, sb[0].d);
      sb.delete();
    end
  endtask

  task automatic idle(input logic rdy);
    step(1, 0, 15'h0, 16'h0, rdy, 0);
  endtask

  vec_t vt[13];

  initial begin
    vt[0]  = '{1, 15'h4005, 16'hAAAA, 1, 1, 0, 13'h0,   16'h0};
    vt[1]  = '{0, 15'h0,    16'h0,    1, 0, 1, 13'h5,   16'hAAAA};
    vt[2]  = '{0, 15'h0,    16'h0,    1, 0, 0, 13'h0,   16'h0};
    vt[3]  = '{1, 15'h3FFF, 16'h1111, 1, 0, 0, 13'h0,   16'h0};
    vt[4]  = '{1, 15'h6000, 16'h2222, 1, 0, 0, 13'h0,   16'h0};
    vt[5]  = '{1, 15'h0010, 16'h3333, 1, 0, 0, 13'h0,   16'h0};
    vt[6]  = '{0, 15'h4000, 16'h4444, 1, 0, 0, 13'h0,   16'h0};
    vt[7]  = '{1, 15'h4100, 16'h0001, 0, 1, 0, 13'h0,   16'h0};
    vt[8]  = '{1, 15'h4100, 16'h0002, 0, 1, 0, 13'h0,   16'h0};
    vt[9]  = '{1, 15'h4101, 16'h0003, 0, 2, 0, 13'h0,   16'h0};
    vt[10] = '{0, 15'h0,    16'h0,    1, 1, 1, 13'h100, 16'h0002};
    vt[11] = '{0, 15'h0,    16'h0,    1, 0, 1, 13'h101, 16'h0003};
    vt[12] = '{0, 15'h0,    16'h0,    1, 0, 0, 13'h0,   16'h0};

    step(0, 0, 15'h0, 16'h0, 0, 0);
    step(0, 0, 15'h0, 16'h0, 0, 0);
    chk("rst_wren", fb_wren, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_data", fb_data, 0);

    for (int i = 0; i < 13; i++) begin
      step(1, vt[i].wm, vt[i].addr, vt[i].data, vt[i].rdy, 0);
      chk($sformatf("v%0d_level", i), level, vt[i].exp_level);
      chk($sformatf("v%0d_wren", i), fb_wren, vt[i].exp_wren);
      if (vt[i].exp_wren) begin
        chk($sformatf("v%0d_addr", i), fb_addr, vt[i].exp_addr);
        chk($sformatf("v%0d_data", i), fb_data, vt[i].exp_data);
      end
    end

    // full FIFO, drops, clear
    for (int i = 0; i < 16; i++)
      step(1, 1, 15'h4200 + 15'(i), 16'h1000 + 16'(i), 0, 0);
    for (int i = 0; i < 3; i++)
      step(1, 1, 15'h4300 + 15'(i), 16'h2000 + 16'(i), 0, 0);
    chk("full_level", level, 16);
    chk("full_ovf", overflow, 1);
    chk("full_drops", drop_cnt, 3);
    step(1, 0, 15'h0, 16'h0, 0, 1);
    chk("clr_ovf", overflow, 0);
    chk("clr_drops", drop_cnt, 0);
    chk("clr_level", level, 16);

    // push and pop together at full
    step(1, 1, 15'h4400, 16'h5555, 1, 0);
    chk("fullpp_level", level, 16);
    chk("fullpp_ovf", overflow, 0);
    chk("fullpp_addr", fb_addr, 13'h200);
    chk("fullpp_data", fb_data, 16'h1000);
    for (int i = 0; i < 16; i++) idle(1);
    chk("drain_level", level, 0);
    chk("drain_last", fb_data, 16'h5555);

    // tail leaving this cycle is not coalesced
    step(1, 1, 15'h4010, 16'h0001, 0, 0);
    step(1, 1, 15'h4010, 16'h0002, 1, 0);
    chk("l1_level", level, 1);
    chk("l1_wr1", fb_data, 16'h0001);
    idle(1);
    chk("l1_wr2", fb_data, 16'h0002);
    chk("l1_wren2", fb_wren, 1);
    idle(1);

    // drop counter saturation, then drop beats clear
    for (int i = 0; i < 16; i++)
      step(1, 1, 15'h4600 + 15'(i), 16'(i), 0, 0);
    for (int i = 0; i < 260; i++)
      step(1, 1, 15'h4800 + 15'(i & 1), 16'(i), 0, 0);
    chk("sat_drops", drop_cnt, 255);
    step(1, 1, 15'h4900, 16'h0, 0, 1);
    chk("clrdrop_ovf", overflow, 1);
    chk("clrdrop_cnt", drop_cnt, 1);
    for (int i = 0; i < 17; i++) idle(1);

    // reset discards pending entries
    for (int i = 0; i < 5; i++)
      step(1, 1, 15'h4500 + 15'(i), 16'hB000 + 16'(i), 0, 0);
    chk("pre_rst_level", level, 5);
    step(0, 0, 15'h0, 16'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("post_rst_wren", fb_wren, 0);
      chk("post_rst_level", level, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
